// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - occupancy, pointer and shift control for a shift-register FIFO
// Optional sticky error flags err_overflow/err_underflow: define FIFO_CTRL_ERR_EN.
module fifo_ctrl #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic             pop,
  output logic             shift_in,
  output logic             shift_out,
  output logic [DEPTH-1:0] in_pointer,
  output logic [DEPTH-1:0] before_in_pointer,
  output logic             full,
  output logic             empty,
`ifdef FIFO_CTRL_ERR_EN
  output logic             err_overflow,
  output logic             err_underflow,
`endif
  output logic [CW-1:0]    count
);

  logic          push_ok;
  logic          pop_ok;
  logic [CW-1:0] count_next;

  // Only a clean 1 counts as a request; X/Z on the handshake never shifts.
  assign push_ok = (push === 1'b1);
  assign pop_ok  = (pop === 1'b1);

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign shift_in  = ~res & push_ok & (~full | pop_ok);
  assign shift_out = ~res & pop_ok & ~empty;

  always_comb begin
    count_next = count;
    if (shift_in & ~shift_out)
      count_next = count + 1'b1;
    else if (shift_out & ~shift_in)
      count_next = count - 1'b1;
  end

  // Flags and pointers are decoded from count_next so they line up with count.
  always_ff @(posedge clk) begin
    if (res) begin
      count             <= '0;
      full              <= 1'b0;
      empty             <= 1'b1;
      in_pointer        <= DEPTH'(1);
      before_in_pointer <= '0;
    end else begin
      count             <= count_next;
      full              <= (count_next == CW'(DEPTH));
      empty             <= (count_next == '0);
      in_pointer        <= DEPTH'(1) << count_next;
      before_in_pointer <= (count_next == '0) ? '0 : (DEPTH'(1) << (count_next - 1'b1));
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  always_ff @(posedge clk) begin
    if (res) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (push_ok & full & ~pop_ok)
        err_overflow <= 1'b1;
      if (pop_ok & empty)
        err_underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - self-checking bench for fifo_ctrl (DEPTH=8) against an occupancy model
module tb_fifo_ctrl;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             res = 1'b1;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             shift_in, shift_out, full, empty;
  logic [DEPTH-1:0] in_pointer, before_in_pointer;
  logic [CW-1:0]    count;
`ifdef FIFO_CTRL_ERR_EN
  logic             err_overflow, err_underflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int ref_count = 0;
  bit chk_en = 1'b0;

  fifo_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .res(res), .push(push), .pop(pop),
    .shift_in(shift_in), .shift_out(shift_out),
    .in_pointer(in_pointer), .before_in_pointer(before_in_pointer),
    .full(full), .empty(empty),
`ifdef FIFO_CTRL_ERR_EN
    .err_overflow(err_overflow), .err_underflow(err_underflow),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Occupancy model: a plain integer moved by the accept rules.
  function automatic bit acc_push(input int occ);
    return !res && (push === 1'b1) && (occ < DEPTH || pop === 1'b1);
  endfunction

  function automatic bit acc_pop(input int occ);
    return !res && (pop === 1'b1) && (occ > 0);
  endfunction

  always @(posedge clk) begin
    if (res)
      ref_count <= 0;
    else
      ref_count <= ref_count + int'(acc_push(ref_count)) - int'(acc_pop(ref_count));
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_shift_in", 32'(shift_in), 32'(acc_push(ref_count)));
      chk("cyc_shift_out", 32'(shift_out), 32'(acc_pop(ref_count)));
      chk("cyc_count", 32'(count), 32'(ref_count));
      chk("cyc_full", 32'(full), 32'(ref_count == DEPTH));
      chk("cyc_empty", 32'(empty), 32'(ref_count == 0));
      chk("cyc_in_ptr", 32'(in_pointer), (ref_count < DEPTH) ? (32'd1 << ref_count) : 32'd0);
      chk("cyc_before_ptr", 32'(before_in_pointer), (ref_count > 0) ? (32'd1 << (ref_count - 1)) : 32'd0);
      chk("cyc_onehot", 32'($countones(in_pointer) <= 1 && $countones(before_in_pointer) <= 1), 32'd1);
    end
  end

  task automatic drive(input logic p, input logic q);
    push = p;
    pop  = q;
    #2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    res = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_in_ptr", 32'(in_pointer), 32'h01);
    chk("rst_before_ptr", 32'(before_in_pointer), 32'h00);
    res = 1'b0;
    chk_en = 1'b1;

    // Fill: pointer walks bit0..bit7, then clears when full.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0);
      chk("fill_shift_in", 32'(shift_in), 32'd1);
      tick();
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_in_ptr", 32'(in_pointer), (i < 8) ? (32'd1 << i) : 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_before_ptr", 32'(before_in_pointer), 32'h80);

    drive(1'b1, 1'b0);
    chk("ovf_shift_in", 32'(shift_in), 32'd0);
    tick();
    chk("ovf_count", 32'(count), 32'd8);
`ifdef FIFO_CTRL_ERR_EN
    chk("ovf_err", 32'(err_overflow), 32'd1);
`endif

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1);
      chk("full_pp_shift_in", 32'(shift_in), 32'd1);
      chk("full_pp_shift_out", 32'(shift_out), 32'd1);
      tick();
      chk("full_pp_count", 32'(count), 32'd8);
      chk("full_pp_before_ptr", 32'(before_in_pointer), 32'h80);
    end

    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1);
      tick();
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);

    drive(1'b1, 1'b1);
    chk("empty_pp_shift_in", 32'(shift_in), 32'd1);
    chk("empty_pp_shift_out", 32'(shift_out), 32'd0);
    tick();
    chk("empty_pp_count", 32'(count), 32'd1);
    chk("empty_pp_empty", 32'(empty), 32'd0);
    chk("empty_pp_before_ptr", 32'(before_in_pointer), 32'h01);

    drive(1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b1);
    chk("udf_shift_out", 32'(shift_out), 32'd0);
    tick();
    chk("udf_count", 32'(count), 32'd0);
`ifdef FIFO_CTRL_ERR_EN
    chk("udf_err", 32'(err_underflow), 32'd1);
`endif

    drive(1'bx, 1'bx);
    chk("x_shift_in", 32'(shift_in), 32'd0);
    chk("x_shift_out", 32'(shift_out), 32'd0);
    tick();
    chk("x_count", 32'(count), 32'd0);

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0);
      tick();
    end
    chk("pre_rst_count", 32'(count), 32'd5);
    res = 1'b1;
    drive(1'b1, 1'b0);
    chk("rst_push_shift_in", 32'(shift_in), 32'd0);
    tick();
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_in_ptr", 32'(in_pointer), 32'h01);
    res = 1'b0;
    drive(1'b1, 1'b0);
    tick();
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_before_ptr", 32'(before_in_pointer), 32'h01);

    // Random traffic with a drifting push bias so both full and empty are visited.
    for (int i = 0; i < 10000; i++) begin
      int bias;
      bias = ((i / 400) % 3 == 0) ? 80 : (((i / 400) % 3 == 1) ? 20 : 50);
      res  = ($urandom_range(0, 999) == 0);
      push = ($urandom_range(0, 99) < bias);
      pop  = ($urandom_range(0, 99) < 50);
      tick();
    end
    res = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
